// File: rtl/axil_cfg_sched_pkg.sv
// Shared types and constants for the AXI-Lite configuration scheduler.
// Holds the scheduler state encoding and AXI response codes.
package axil_cfg_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } sched_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // SLVERR and DECERR both have the upper response bit set
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axil_cfg_sched_if.sv
// AXI-Lite bus bundle shared by the scheduler and whatever slave sits behind it.
// The master side drives valids, addresses and write data; the slave returns readies and responses.
interface axi_lite #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axil_cfg_sched_rr_arb.sv
// Combinational round-robin arbiter: picks the first set request at or after ptr,
// wrapping modulo NUM_REQ, and reports it both one-hot and as a binary index.
module rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any_req
);

    logic found;
    int   pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IW'(pos);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/axil_cfg_sched.sv
// Round-robin scheduler sharing one AXI-Lite master among NUM_REQ register requesters,
// one 32-bit read or write outstanding at a time.
module axil_cfg_sched
    import axil_cfg_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              sys_clk,
    input  logic                              ic_rst_n,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0]                we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   wstrb,
    output logic [NUM_REQ-1:0]                done,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic                              err,
    output logic                              busy,
    axi_lite.master                           m_axil
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = DATA_WIDTH / 8;

    sched_state_t state, state_nxt;

    logic [IW-1:0]         ptr;
    logic [IW-1:0]         gnt_idx;
    logic [IW-1:0]         arb_idx;
    logic [NUM_REQ-1:0]    arb_grant;
    logic                  any_req;
    logic                  we_sel;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [SW-1:0]         lat_wstrb;
    logic                  aw_done;
    logic                  w_done;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic awvalid_c, wvalid_c, bready_c, arvalid_c, rready_c;

    rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_arb (
        .req     (req),
        .ptr     (ptr),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .any_req (any_req)
    );

    assign we_sel = |(we & arb_grant);

    assign aw_hs = awvalid_c & m_axil.awready;
    assign w_hs  = wvalid_c  & m_axil.wready;
    assign b_hs  = bready_c  & m_axil.bvalid;
    assign ar_hs = arvalid_c & m_axil.arready;
    assign r_hs  = rready_c  & m_axil.rvalid;

    always_ff @(posedge sys_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // AW and W drop independently; the write phase ends once both have been accepted
    always_comb begin
        state_nxt = state;
        awvalid_c = 1'b0;
        wvalid_c  = 1'b0;
        bready_c  = 1'b0;
        arvalid_c = 1'b0;
        rready_c  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = we_sel ? WR : RD_ADDR;
            end
            WR: begin
                awvalid_c = !aw_done;
                wvalid_c  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bready_c = 1'b1;
                if (b_hs) state_nxt = DONE;
            end
            RD_ADDR: begin
                arvalid_c = 1'b1;
                if (ar_hs) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rready_c = 1'b1;
                if (r_hs) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured only at grant time, so requester changes mid-flight are ignored
    always_ff @(posedge sys_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            ptr       <= '0;
            gnt_idx   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_idx   <= arb_idx;
                        ptr       <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
                        lat_addr  <= addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        lat_wdata <= wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                        lat_wstrb <= wstrb[int'(arb_idx)*SW +: SW];
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                    end
                end
                WR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (b_hs) err <= resp_is_err(m_axil.bresp);
                end
                RD_DATA: begin
                    if (r_hs) begin
                        rdata <= m_axil.rdata;
                        err   <= resp_is_err(m_axil.rresp);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        done = '0;
        if (state == DONE) done[gnt_idx] = 1'b1;
    end

    assign busy = (state != IDLE);

    assign m_axil.awvalid = awvalid_c;
    assign m_axil.wvalid  = wvalid_c;
    assign m_axil.bready  = bready_c;
    assign m_axil.arvalid = arvalid_c;
    assign m_axil.rready  = rready_c;
    assign m_axil.awaddr  = lat_addr;
    assign m_axil.araddr  = lat_addr;
    assign m_axil.wdata   = lat_wdata;
    assign m_axil.wstrb   = lat_wstrb;

endmodule

// File: tb/tb_axil_cfg_sched.sv
// Directed bench for axil_cfg_sched with a configurable-latency AXI-Lite slave model.
// Slave read data is cfg_rdata XOR the accepted address so each grant's address is visible.
module tb_axil_cfg_sched;
    import axil_cfg_sched_pkg::*;

    localparam int NUM_REQ = 4;

    logic        sys_clk  = 1'b0;
    logic        ic_rst_n = 1'b0;
    logic [3:0]  req      = '0;
    logic [3:0]  we       = '0;
    logic [127:0] addr    = '0;
    logic [127:0] wdata   = '0;
    logic [15:0] wstrb    = '0;
    logic [3:0]  done;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    axi_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

    axil_cfg_sched #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .sys_clk  (sys_clk),
        .ic_rst_n (ic_rst_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .busy     (busy),
        .m_axil   (axil)
    );

    always #5 sys_clk = ~sys_clk;

    // Slave model: each ready rises after its valid has waited *_lat cycles
    int          aw_lat = 0, w_lat = 0, ar_lat = 0;
    logic [1:0]  cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;
    logic [31:0] cfg_rdata = '0;
    int          aw_wait, w_wait, ar_wait;
    logic        aw_got, w_got, r_pend;
    logic [31:0] ar_addr_q;
    logic        slv_bvalid, slv_rvalid;
    logic [1:0]  slv_bresp, slv_rresp;
    logic [31:0] slv_rdata;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic        tb_aw_hs, tb_w_hs, tb_ar_hs;

    assign axil.awready = axil.awvalid && (aw_wait >= aw_lat);
    assign axil.wready  = axil.wvalid  && (w_wait  >= w_lat);
    assign axil.arready = axil.arvalid && (ar_wait >= ar_lat);
    assign axil.bvalid  = slv_bvalid;
    assign axil.bresp   = slv_bresp;
    assign axil.rvalid  = slv_rvalid;
    assign axil.rdata   = slv_rdata;
    assign axil.rresp   = slv_rresp;
    assign tb_aw_hs = axil.awvalid && axil.awready;
    assign tb_w_hs  = axil.wvalid  && axil.wready;
    assign tb_ar_hs = axil.arvalid && axil.arready;

    always @(posedge sys_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            ar_addr_q <= '0;
            slv_bvalid <= 1'b0; slv_bresp <= 2'b00;
            slv_rvalid <= 1'b0; slv_rresp <= 2'b00; slv_rdata <= '0;
        end else begin
            aw_wait <= (axil.awvalid && !axil.awready) ? aw_wait + 1 : 0;
            w_wait  <= (axil.wvalid  && !axil.wready)  ? w_wait + 1  : 0;
            ar_wait <= (axil.arvalid && !axil.arready) ? ar_wait + 1 : 0;
            if (tb_aw_hs) aw_cnt <= aw_cnt + 1;
            if (tb_w_hs)  w_cnt  <= w_cnt + 1;
            if ((aw_got || tb_aw_hs) && (w_got || tb_w_hs) && !slv_bvalid) begin
                slv_bvalid <= 1'b1;
                slv_bresp  <= cfg_bresp;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end else begin
                if (tb_aw_hs) aw_got <= 1'b1;
                if (tb_w_hs)  w_got  <= 1'b1;
            end
            if (slv_bvalid && axil.bready) begin
                slv_bvalid <= 1'b0;
                b_cnt      <= b_cnt + 1;
            end
            if (tb_ar_hs) begin
                ar_addr_q <= axil.araddr;
                r_pend    <= 1'b1;
            end
            if (r_pend) begin
                r_pend     <= 1'b0;
                slv_rvalid <= 1'b1;
                slv_rdata  <= cfg_rdata ^ ar_addr_q;
                slv_rresp  <= cfg_rresp;
            end
            if (slv_rvalid && axil.rready) slv_rvalid <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
        we[idx]             = w;
        addr[idx*32 +: 32]  = a;
        wdata[idx*32 +: 32] = d;
        wstrb[idx*4 +: 4]   = s;
        req[idx]            = 1'b1;
    endtask

    task automatic wait_done(output logic [3:0] seen);
        bit hit;
        hit  = 1'b0;
        seen = '0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge sys_clk);
            if (done != 4'b0) begin
                seen = done;
                hit  = 1'b1;
            end
        end
        if (!hit) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] seen;
        int         ar_cycles;
        int         aw0, w0, b0;
        int         order [6] = '{0, 1, 2, 3, 0, 1};
        bit         hit;

        repeat (2) @(negedge sys_clk);
        checkOutput("rst_busy",    busy,         0);
        checkOutput("rst_done",    done,         0);
        checkOutput("rst_rdata",   rdata,        0);
        checkOutput("rst_err",     err,          0);
        checkOutput("rst_awvalid", axil.awvalid, 0);
        checkOutput("rst_wvalid",  axil.wvalid,  0);
        checkOutput("rst_arvalid", axil.arvalid, 0);
        checkOutput("rst_bready",  axil.bready,  0);
        checkOutput("rst_rready",  axil.rready,  0);
        checkOutput("rst_awaddr",  axil.awaddr,  0);
        checkOutput("rst_wdata",   axil.wdata,   0);
        checkOutput("rst_wstrb",   axil.wstrb,   0);
        ic_rst_n = 1'b1;
        @(negedge sys_clk);

        $display("[TB] contention: all four requesters");
        cfg_rdata = 32'hA5A5_0000;
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0, 32'h100 * i, 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            wait_done(seen);
            checkOutput($sformatf("rr_done_%0d", k), seen, 4'b1 << order[k]);
            checkOutput($sformatf("rr_rdata_%0d", k), rdata, 32'hA5A5_0000 ^ (32'h100 * order[k]));
            if (k == 5) req = '0;
        end
        @(negedge sys_clk);

        $display("[TB] single write, always-ready slave");
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        @(negedge sys_clk);
        checkOutput("wr_c1_awvalid", axil.awvalid, 1);
        checkOutput("wr_c1_wvalid",  axil.wvalid,  1);
        checkOutput("wr_c1_awaddr",  axil.awaddr,  32'h10);
        checkOutput("wr_c1_wdata",   axil.wdata,   32'hDEAD_BEEF);
        checkOutput("wr_c1_wstrb",   axil.wstrb,   4'hF);
        checkOutput("wr_c1_busy",    busy,         1);
        @(negedge sys_clk);
        checkOutput("wr_c2_bready",  axil.bready,  1);
        checkOutput("wr_c2_awvalid", axil.awvalid, 0);
        checkOutput("wr_c2_done",    done,         0);
        @(negedge sys_clk);
        checkOutput("wr_c3_done",    done,         4'b0001);
        checkOutput("wr_c3_err",     err,          0);
        req[0] = 1'b0;
        @(negedge sys_clk);
        checkOutput("wr_c4_done",    done,         0);
        checkOutput("wr_c4_busy",    busy,         0);
        checkOutput("wr_aw_count",   aw_cnt - aw0, 1);
        checkOutput("wr_w_count",    w_cnt - w0,   1);
        checkOutput("wr_b_count",    b_cnt - b0,   1);

        $display("[TB] read with arready delayed two cycles");
        cfg_rdata = 32'h0011_4514;
        ar_lat    = 2;
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0);
        ar_cycles = 0;
        hit       = 1'b0;
        seen      = '0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge sys_clk);
            if (axil.arvalid) ar_cycles++;
            if (done != 4'b0) begin
                seen = done;
                hit  = 1'b1;
            end
        end
        checkOutput("rd_ar_cycles", ar_cycles, 3);
        checkOutput("rd_done",      seen,      4'b0010);
        checkOutput("rd_rdata",     rdata,     32'h0011_4514);
        checkOutput("rd_err",       err,       0);
        req[1] = 1'b0;
        ar_lat = 0;
        @(negedge sys_clk);

        $display("[TB] split AW/W handshake");
        w_lat = 3;
        aw0 = aw_cnt; b0 = b_cnt;
        applyStimulus(2, 1'b1, 32'h20, 32'h1234_5678, 4'h3);
        @(negedge sys_clk);
        checkOutput("sp_c1_awvalid", axil.awvalid, 1);
        checkOutput("sp_c1_wvalid",  axil.wvalid,  1);
        @(negedge sys_clk);
        checkOutput("sp_c2_awvalid", axil.awvalid, 0);
        checkOutput("sp_c2_wvalid",  axil.wvalid,  1);
        @(negedge sys_clk);
        checkOutput("sp_c3_wvalid",  axil.wvalid,  1);
        checkOutput("sp_c3_bready",  axil.bready,  0);
        @(negedge sys_clk);
        checkOutput("sp_c4_wvalid",  axil.wvalid,  1);
        checkOutput("sp_c4_bready",  axil.bready,  0);
        @(negedge sys_clk);
        checkOutput("sp_c5_wvalid",  axil.wvalid,  0);
        checkOutput("sp_c5_bready",  axil.bready,  1);
        @(negedge sys_clk);
        checkOutput("sp_c6_done",    done,         4'b0100);
        req[2] = 1'b0;
        @(negedge sys_clk);
        checkOutput("sp_aw_count",   aw_cnt - aw0, 1);
        checkOutput("sp_b_count",    b_cnt - b0,   1);
        w_lat = 0;

        $display("[TB] error responses");
        cfg_bresp = RESP_SLVERR;
        applyStimulus(3, 1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF);
        wait_done(seen);
        checkOutput("er_wr_done", seen, 4'b1000);
        checkOutput("er_wr_err",  err,  1);
        req[3] = 1'b0;
        cfg_bresp = RESP_OKAY;
        cfg_rresp = RESP_OKAY;
        cfg_rdata = 32'h5555_0000;
        @(negedge sys_clk);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'h0);
        wait_done(seen);
        checkOutput("er_rd_ok_done",  seen,  4'b0001);
        checkOutput("er_rd_ok_err",   err,   0);
        checkOutput("er_rd_ok_rdata", rdata, 32'h5555_0008);
        req[0] = 1'b0;
        cfg_rresp = RESP_DECERR;
        @(negedge sys_clk);
        applyStimulus(1, 1'b0, 32'hC, 32'h0, 4'h0);
        wait_done(seen);
        checkOutput("er_rd_dec_done", seen, 4'b0010);
        checkOutput("er_rd_dec_err",  err,  1);
        req[1] = 1'b0;
        cfg_rresp = RESP_OKAY;
        @(negedge sys_clk);

        $display("[TB] reset during read data phase");
        applyStimulus(1, 1'b0, 32'h40, 32'h0, 4'h0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge sys_clk);
            if (axil.rready) hit = 1'b1;
        end
        checkOutput("mr_rready_seen", axil.rready, 1);
        checkOutput("mr_busy_before", busy,        1);
        #2 ic_rst_n = 1'b0;
        #1;
        checkOutput("mr_busy",    busy,         0);
        checkOutput("mr_rready",  axil.rready,  0);
        checkOutput("mr_done",    done,         0);
        checkOutput("mr_arvalid", axil.arvalid, 0);
        req[1] = 1'b0;
        repeat (2) @(negedge sys_clk);
        ic_rst_n = 1'b1;
        @(negedge sys_clk);
        cfg_rdata = 32'h0BAD_F00D;
        applyStimulus(1, 1'b0, 32'h44, 32'h0, 4'h0);
        applyStimulus(2, 1'b0, 32'h48, 32'h0, 4'h0);
        wait_done(seen);
        checkOutput("pr_first_done", seen,  4'b0010);
        checkOutput("pr_first_data", rdata, 32'h0BAD_F00D ^ 32'h44);
        req[1] = 1'b0;
        wait_done(seen);
        checkOutput("pr_req2_done",  seen,  4'b0100);
        checkOutput("pr_req2_data",  rdata, 32'h0BAD_F00D ^ 32'h48);
        checkOutput("pr_req2_err",   err,   0);
        req[2] = 1'b0;
        repeat (2) @(negedge sys_clk);
        checkOutput("end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
